// File: rtl/serial_route_ctrl.sv
// Serial packet router for the 1-to-4 demux: decodes a 2-bit header, streams the
// payload with the selects held steady, checks trailing even parity, counts good packets.
module serial_route_ctrl #(
  parameter int PAYLOAD_LEN = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               din,
  input  logic               clr_cnt,
  output logic               s1,
  output logic               s0,
  output logic               dout,
  output logic               dout_vld,
  output logic               busy,
  output logic               pkt_done,
  output logic               par_err,
  output logic [4*CNT_W-1:0] pkt_cnt
);

  // state | meaning
  // IDLE  | waiting for start, selects hold last header, dout parked at 0
  // HDR1  | sampling header MSB
  // HDR0  | sampling header LSB, selects load on this edge
  // PAY   | streaming payload bits to dout
  // PAR   | sampling the trailing parity bit
  typedef enum logic [2:0] {IDLE, HDR1, HDR0, PAY, PAR} state_t;

  localparam logic [7:0] LAST = 8'(PAYLOAD_LEN - 1);

  state_t           state_q, state_d;
  logic             h1_q;
  logic             par_q;
  logic [7:0]       pcnt_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [1:0]       sel;
  logic             good;

  assign sel     = {s1, s0};
  assign busy    = (state_q != IDLE);
  assign good    = (state_q == PAR) && !(par_q ^ din);
  assign pkt_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HDR1;
      HDR1:    state_d = HDR0;
      HDR0:    state_d = PAY;
      PAY:     if (pcnt_q == LAST) state_d = PAR;
      PAR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h1_q     <= 1'b0;
      par_q    <= 1'b0;
      pcnt_q   <= 8'd0;
      s1       <= 1'b0;
      s0       <= 1'b0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      pkt_done <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      pkt_done <= 1'b0;
      par_err  <= 1'b0;
      case (state_q)
        HDR1: h1_q <= din;
        HDR0: begin
          s1     <= h1_q;
          s0     <= din;
          pcnt_q <= 8'd0;
          par_q  <= h1_q ^ din;
        end
        PAY: begin
          dout     <= din;
          dout_vld <= 1'b1;
          par_q    <= par_q ^ din;
          if (pcnt_q != LAST) pcnt_q <= pcnt_q + 8'd1;
        end
        PAR: begin
          pkt_done <= 1'b1;
          par_err  <= par_q ^ din;
        end
        default: ;
      endcase
    end
  end

  // clear beats a same-cycle increment; counters stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (good && (cnt_q[sel] != '1)) begin
      cnt_q[sel] <= cnt_q[sel] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_route_ctrl.sv
// Self-checking bench for serial_route_ctrl: directed vector table, corner sequences,
// and randomized packets against a packet-level model of routing, parity and counts.
module tb_serial_route_ctrl;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        din = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        s1, s0, dout, dout_vld, busy, pkt_done, par_err;
  logic [31:0] pkt_cnt;
  logic        s1_b, s0_b, dout_b, dout_vld_b, busy_b, pkt_done_b, par_err_b;
  logic [7:0]  pkt_cnt_b;

  int checks = 0;
  int failures = 0;

  logic [1:0] exp_sel = 2'b00;
  int m8 [4];
  int m2 [4];

  always #5 clk = ~clk;

  serial_route_ctrl #(.PAYLOAD_LEN(N), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .clr_cnt(clr_cnt),
    .s1(s1), .s0(s0), .dout(dout), .dout_vld(dout_vld), .busy(busy),
    .pkt_done(pkt_done), .par_err(par_err), .pkt_cnt(pkt_cnt)
  );

  serial_route_ctrl #(.PAYLOAD_LEN(N), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .clr_cnt(clr_cnt),
    .s1(s1_b), .s0(s0_b), .dout(dout_b), .dout_vld(dout_vld_b), .busy(busy_b),
    .pkt_done(pkt_done_b), .par_err(par_err_b), .pkt_cnt(pkt_cnt_b)
  );

  typedef struct {
    logic [1:0] hdr;
    logic [7:0] pay;
    logic       pbit;
    bit         clr;
    bit         rst_before;
    bit         noisy;
    bit         exp_err;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack8();
    return {8'(m8[3]), 8'(m8[2]), 8'(m8[1]), 8'(m8[0])};
  endfunction

  function automatic logic [7:0] pack2();
    return {2'(m2[3]), 2'(m2[2]), 2'(m2[1]), 2'(m2[0])};
  endfunction

  task automatic model_reset();
    exp_sel = 2'b00;
    for (int i = 0; i < 4; i++) begin
      m8[i] = 0;
      m2[i] = 0;
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_outs"}, {25'd0, s1, s0, dout, dout_vld, busy, pkt_done, par_err}, 32'd0);
    chk({name, "_cnt"}, pkt_cnt, 32'd0);
    chk({name, "_cnt_b"}, {24'd0, pkt_cnt_b}, 32'd0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    clr_cnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset");
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Starts in the cycle where start is driven (cycle 0) and ends in cycle N+4.
  task automatic run_pkt(input logic [1:0] hdr, input logic [7:0] pay, input logic pbit,
                         input bit clr, input bit noisy, input bit exp_err, input int abort_at);
    logic [1:0] old_sel;
    logic       exp_vld, exp_dout;
    int         idx;
    old_sel = exp_sel;
    start = 1'b1;
    din = 1'($urandom);
    clr_cnt = 1'b0;
    for (int c = 1; c <= N + 4; c++) begin
      tick();
      start = 1'b0;
      clr_cnt = 1'b0;
      exp_vld = (c >= 4) && (c <= N + 3);
      idx = N - 1 - (c - 4);
      exp_dout = exp_vld ? pay[idx] : 1'b0;
      chk("busy", {31'd0, busy}, {31'd0, (c <= N + 3)});
      chk("sel", {30'd0, s1, s0}, {30'd0, (c >= 3) ? hdr : old_sel});
      chk("dout_vld", {31'd0, dout_vld}, {31'd0, exp_vld});
      chk("dout", {31'd0, dout}, {31'd0, exp_dout});
      chk("pkt_done", {31'd0, pkt_done}, {31'd0, (c == N + 4)});
      chk("par_err", {31'd0, par_err}, {31'd0, (c == N + 4) && exp_err});
      if (c == N + 4) begin
        exp_sel = hdr;
        if (clr) begin
          for (int i = 0; i < 4; i++) begin
            m8[i] = 0;
            m2[i] = 0;
          end
        end else if (!exp_err) begin
          if (m8[hdr] < 255) m8[hdr]++;
          if (m2[hdr] < 3) m2[hdr]++;
        end
      end
      chk("pkt_cnt", pkt_cnt, pack8());
      chk("pkt_cnt_b", {24'd0, pkt_cnt_b}, {24'd0, pack2()});
      if (c == 1) din = hdr[1];
      else if (c == 2) din = hdr[0];
      else if (c <= N + 2) begin
        idx = N - 1 - (c - 3);
        din = pay[idx];
      end else if (c == N + 3) begin
        din = pbit;
        clr_cnt = clr;
      end else din = 1'b0;
      if (noisy && (c == 2 || c == 5 || c == 10)) start = 1'b1;
      if (c == abort_at) begin
        start = 1'b0;
        clr_cnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        model_reset();
        tick();
        tick();
        chk_reset_vals("abort_hold");
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [1:0] hdr;
    logic [7:0] pay;
    logic       pbit, eerr;
    int         gap;

    vt[0] = '{2'b10, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{2'b10, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{2'b00, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{2'b01, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{2'b11, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{2'b11, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{2'b10, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    model_reset();
    #1;
    chk_reset_vals("por");
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vt[i].rst_before) do_reset();
      run_pkt(vt[i].hdr, vt[i].pay, vt[i].pbit, vt[i].clr, vt[i].noisy, vt[i].exp_err, 0);
      if (i == 0) chk("first_pkt_cnt2", pkt_cnt, 32'h0001_0000);
      if (i == 1) chk("bad_pkt_cnt2", pkt_cnt, 32'h0001_0000);
      if (i == 5) chk("b2b_cnts", pkt_cnt, 32'h0200_0101);
    end

    // reset in cycle 6 of a packet, then a fresh packet
    start = 1'b0;
    din = 1'b0;
    tick();
    run_pkt(2'b01, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    run_pkt(2'b11, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("post_abort_cnt", pkt_cnt, 32'h0100_0000);

    // saturation on the narrow counters, then clear racing an increment
    do_reset();
    for (int i = 0; i < 5; i++) run_pkt(2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk("sat_cnt1_b", {30'd0, pkt_cnt_b[3:2]}, 32'd3);
    chk("sat_cnt1_wide", pkt_cnt, 32'h0000_0500);
    run_pkt(2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("clr_wins_b", {24'd0, pkt_cnt_b}, 32'd0);
    chk("clr_wins", pkt_cnt, 32'd0);

    for (int r = 0; r < 40; r++) begin
      hdr = 2'($urandom);
      pay = 8'($urandom);
      pbit = (^{hdr, pay}) ^ ($urandom_range(0, 3) == 0);
      eerr = ^{hdr, pay, pbit};
      run_pkt(hdr, pay, pbit, ($urandom_range(0, 9) == 0), 1'($urandom), eerr, 0);
      gap = $urandom_range(0, 2);
      start = 1'b0;
      din = 1'($urandom);
      for (int g = 0; g < gap; g++) begin
        tick();
        din = 1'($urandom);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_dout", {30'd0, dout_vld, dout}, 32'd0);
        chk("idle_sel", {30'd0, s1, s0}, {30'd0, exp_sel});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
